// File: rtl/axis_width_downsizer_pkg.sv
// Shared constants and state encoding for the 256->64 AXI4-Stream width downsizer.
package axis_width_downsizer_pkg;

  localparam int S_DATA_W = 256;
  localparam int M_DATA_W = 64;
  localparam int USER_W   = 1;
  localparam int RATIO    = S_DATA_W / M_DATA_W;
  localparam int IDX_W    = $clog2(RATIO);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_DRAIN = 1'b1
  } dwc_state_e;

endpackage

// File: rtl/axis_width_downsizer_if.sv
// AXI4-Stream bundle shared by the wide (slave) and narrow (master) sides of the downsizer.
interface axis_width_downsizer_if
  import axis_width_downsizer_pkg::*;
#(
  parameter int DATA_W = M_DATA_W,
  parameter int USER_W_P = USER_W
);

  localparam int KEEP_W = DATA_W / 8;

  logic [DATA_W-1:0]   tdata;
  logic [KEEP_W-1:0]   tkeep;
  logic [USER_W_P-1:0] tuser;
  logic                tvalid;
  logic                tready;
  logic                tlast;

  modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);

endinterface

// File: rtl/axis_width_downsizer_keep_last_lane.sv
// Priority encoder: index of the highest narrow lane whose keep chunk has any byte set (0 if none).
module axis_keep_last_lane
  import axis_width_downsizer_pkg::*;
#(
  parameter int KEEP_W     = S_DATA_W / 8,
  parameter int LANES      = RATIO,
  parameter int LANE_IDX_W = IDX_W
) (
  input  logic [KEEP_W-1:0]     keep,
  output logic [LANE_IDX_W-1:0] last_idx
);

  localparam int CHUNK_W = KEEP_W / LANES;

  always_comb begin
    last_idx = '0;
    for (int i = 0; i < LANES; i++) begin
      if (|keep[i*CHUNK_W +: CHUNK_W]) last_idx = LANE_IDX_W'(i);
    end
  end

endmodule

// File: rtl/axis_width_downsizer.sv
// Wide-to-narrow AXI4-Stream converter with one-word holding register; trailing empty lanes of a
// frame's last word are skipped. Optional counters stat_frames/stat_nullend under DWC_STATS_EN.
module axis_width_downsizer
  import axis_width_downsizer_pkg::*;
#(
  parameter int C_S_DATA_WIDTH = S_DATA_W,
  parameter int C_M_DATA_WIDTH = M_DATA_W,
  parameter int C_USER_WIDTH   = USER_W
) (
  input  logic                   axi_aclk,
  input  logic                   axi_resetn,
  axis_width_downsizer_if.slave  s_axis,
  axis_width_downsizer_if.master m_axis
`ifdef DWC_STATS_EN
  ,
  output logic [31:0]            stat_frames,
  output logic [31:0]            stat_nullend
`endif
);

  localparam int LANES      = C_S_DATA_WIDTH / C_M_DATA_WIDTH;
  localparam int LANE_IDX_W = $clog2(LANES);
  localparam int S_KEEP_W   = C_S_DATA_WIDTH / 8;
  localparam int M_KEEP_W   = C_M_DATA_WIDTH / 8;

  dwc_state_e              state_q, state_d;
  logic [LANE_IDX_W-1:0]   idx_q, idx_d;
  logic [LANE_IDX_W-1:0]   end_idx_q;
  logic [LANE_IDX_W-1:0]   cap_last_idx;
  logic [C_S_DATA_WIDTH-1:0] buf_data;
  logic [S_KEEP_W-1:0]     buf_keep;
  logic [C_USER_WIDTH-1:0] buf_user;
  logic                    buf_last;
  logic                    m_fire, s_fire, word_done, s_ready;

  axis_keep_last_lane #(
    .KEEP_W     (S_KEEP_W),
    .LANES      (LANES),
    .LANE_IDX_W (LANE_IDX_W)
  ) u_keep_last_lane (
    .keep     (s_axis.tkeep),
    .last_idx (cap_last_idx)
  );

  // A new word may load in the very cycle the final beat of the current word leaves.
  always_comb begin
    m_fire    = (state_q == ST_DRAIN) && m_axis.tready;
    word_done = m_fire && (idx_q == end_idx_q);
    s_ready   = (state_q == ST_EMPTY) || word_done;
    s_fire    = s_axis.tvalid && s_ready;
    state_d   = state_q;
    idx_d     = idx_q;
    case (state_q)
      ST_EMPTY: begin
        if (s_fire) begin
          state_d = ST_DRAIN;
          idx_d   = '0;
        end
      end
      ST_DRAIN: begin
        if (word_done) begin
          state_d = s_fire ? ST_DRAIN : ST_EMPTY;
          idx_d   = '0;
        end else if (m_fire) begin
          idx_d = idx_q + LANE_IDX_W'(1);
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q <= ST_EMPTY;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // The end lane is resolved at capture so the drain path only does an equality compare.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      buf_data  <= '0;
      buf_keep  <= '0;
      buf_user  <= '0;
      buf_last  <= 1'b0;
      end_idx_q <= '0;
    end else if (s_fire) begin
      buf_data  <= s_axis.tdata;
      buf_keep  <= s_axis.tkeep;
      buf_user  <= s_axis.tuser;
      buf_last  <= s_axis.tlast;
      end_idx_q <= s_axis.tlast ? cap_last_idx : LANE_IDX_W'(LANES - 1);
    end
  end

  assign s_axis.tready = s_ready;
  assign m_axis.tvalid = (state_q == ST_DRAIN);
  assign m_axis.tdata  = buf_data[int'(idx_q)*C_M_DATA_WIDTH +: C_M_DATA_WIDTH];
  assign m_axis.tkeep  = buf_keep[int'(idx_q)*M_KEEP_W +: M_KEEP_W];
  assign m_axis.tuser  = buf_user;
  assign m_axis.tlast  = (state_q == ST_DRAIN) && buf_last && (idx_q == end_idx_q);

`ifdef DWC_STATS_EN
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      stat_frames  <= '0;
      stat_nullend <= '0;
    end else begin
      if (m_fire && m_axis.tlast) stat_frames <= stat_frames + 32'd1;
      if (s_fire && s_axis.tlast && (s_axis.tkeep == '0)) stat_nullend <= stat_nullend + 32'd1;
    end
  end
`endif

endmodule
